// File: rtl/readout_rx_bin_accumulator_multi_pkg.sv
// readout_rx_bin_accumulator_multi_pkg: shared FSM states and midpoint helper for the bin accumulator.
package readout_rx_bin_accumulator_multi_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2} state_t;
   function automatic logic [63:0] midpoint(input int w);
      return 64'd1 << (w - 1);
   endfunction
endpackage

// File: rtl/readout_rx_bin_accumulator_multi_if.sv
// readout_rx_bin_accumulator_multi_if: sample/window handshake and result bus of the bin accumulator.
interface readout_rx_bin_accumulator_multi_if #(
   parameter int NUM_CHANNEL = 4,
   parameter int BIN_COUNTER_WIDTH = 16,
   parameter int WINDOW_LEN_WIDTH = 16
);
   logic start_count;
   logic [WINDOW_LEN_WIDTH-1:0] window_len;
   logic valid_in;
   logic [NUM_CHANNEL-1:0] count_condition;
   logic [NUM_CHANNEL*BIN_COUNTER_WIDTH-1:0] bin_count_out;
   logic [NUM_CHANNEL-1:0] state_out;
   logic done_out;
   logic busy_out;
   modport master (
      output start_count, window_len, valid_in, count_condition,
      input bin_count_out, state_out, done_out, busy_out
   );
   modport slave (
      input start_count, window_len, valid_in, count_condition,
      output bin_count_out, state_out, done_out, busy_out
   );
endinterface

// File: rtl/readout_rx_sat_updown_counter.sv
// readout_rx_sat_updown_counter: loadable up/down counter that saturates at zero and all-ones.
module readout_rx_sat_updown_counter #(
   parameter int WIDTH = 16
) (
   input logic clk,
   input logic rst,
   input logic load,
   input logic [WIDTH-1:0] load_value,
   input logic en,
   input logic up,
   output logic [WIDTH-1:0] count_out
);
   logic at_limit;
   assign at_limit = up ? &count_out : ~|count_out;
   always_ff @(posedge clk) begin
      if (rst) count_out <= '0;
      else if (load) count_out <= load_value;
      else if (en && !at_limit) count_out <= up ? count_out + WIDTH'(1) : count_out - WIDTH'(1);
   end
endmodule

// File: rtl/readout_rx_bin_accumulator_multi.sv
// readout_rx_bin_accumulator_multi: per-channel saturating bin counters over a window of valid samples,
// with a done pulse and latched MSB decisions at window end.
module readout_rx_bin_accumulator_multi
   import readout_rx_bin_accumulator_multi_pkg::*;
#(
   parameter int NUM_CHANNEL = 4,
   parameter int BIN_COUNTER_WIDTH = 16,
   parameter int WINDOW_LEN_WIDTH = 16
) (
   input logic clk,
   input logic rst,
   readout_rx_bin_accumulator_multi_if.slave bus
);
   localparam int W = BIN_COUNTER_WIDTH;
   localparam logic [W-1:0] MID = W'(midpoint(W));
   state_t state;
   logic [WINDOW_LEN_WIDTH-1:0] remaining;
   logic [NUM_CHANNEL-1:0] msb_next, state_q;
   logic [NUM_CHANNEL*W-1:0] counts;
   logic count_en, last, done_q, busy_q;
   assign count_en = state == COUNT && bus.valid_in;
   assign last = count_en && remaining == WINDOW_LEN_WIDTH'(1);
   for (genvar i = 0; i < NUM_CHANNEL; i++) begin : g_ch
      logic [W-1:0] c;
      readout_rx_sat_updown_counter #(.WIDTH(W)) u_cnt (
         .clk(clk),
         .rst(rst),
         .load(bus.start_count),
         .load_value(MID),
         .en(count_en),
         .up(bus.count_condition[i]),
         .count_out(c)
      );
      assign counts[i*W +: W] = c;
      // MSB after this cycle's saturating step, so the decision lands with done_out
      assign msb_next[i] = bus.count_condition[i] ? c[W-1] | (&c[W-2:0]) : c[W-1] & (|c[W-2:0]);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         remaining <= '0;
         state_q <= '0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else if (bus.start_count) begin
         remaining <= bus.window_len;
         state <= bus.window_len == '0 ? DONE : COUNT;
         busy_q <= bus.window_len != '0;
         done_q <= bus.window_len == '0;
         if (bus.window_len == '0) state_q <= {NUM_CHANNEL{MID[W-1]}};
      end else begin
         done_q <= last;
         busy_q <= state == COUNT && !last;
         if (count_en) remaining <= remaining - WINDOW_LEN_WIDTH'(1);
         if (last) state_q <= msb_next;
         state <= last ? DONE : state == COUNT ? COUNT : IDLE;
      end
   end
   assign bus.bin_count_out = counts;
   assign bus.state_out = state_q;
   assign bus.done_out = done_q;
   assign bus.busy_out = busy_q;
endmodule

// File: tb/tb_readout_rx_bin_accumulator_multi.sv
// tb_readout_rx_bin_accumulator_multi: directed stimulus against a clipped-integer window model of the accumulator.
module tb_readout_rx_bin_accumulator_multi;
   localparam int NC = 4;
   localparam int W = 8;
   localparam int WL = 8;
   localparam int MIDV = 1 << (W - 1);
   localparam int MAXV = (1 << W) - 1;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   readout_rx_bin_accumulator_multi_if #(.NUM_CHANNEL(NC), .BIN_COUNTER_WIDTH(W), .WINDOW_LEN_WIDTH(WL)) bus ();
   readout_rx_bin_accumulator_multi #(.NUM_CHANNEL(NC), .BIN_COUNTER_WIDTH(W), .WINDOW_LEN_WIDTH(WL)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );
   int checks = 0;
   int failures = 0;
   int m_cnt[NC];
   int m_left = 0;
   bit m_win = 0, m_done = 0, m_busy = 0, m_live = 0;
   logic [NC-1:0] m_state = '0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask
   // Model: counters are plain integers clipped to [0, MAXV]; a window is a count of samples still owed.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NC; i++) m_cnt[i] = 0;
         m_left = 0; m_win = 0; m_done = 0; m_busy = 0; m_state = '0; m_live = 1;
      end else if (bus.start_count) begin
         for (int i = 0; i < NC; i++) m_cnt[i] = MIDV;
         m_left = int'(bus.window_len);
         m_win = m_left != 0;
         m_busy = m_win;
         m_done = !m_win;
         if (!m_win) for (int i = 0; i < NC; i++) m_state[i] = m_cnt[i] >= MIDV;
      end else begin
         m_done = 0;
         if (m_win && bus.valid_in) begin
            for (int i = 0; i < NC; i++)
               m_cnt[i] = bus.count_condition[i] ? (m_cnt[i] == MAXV ? MAXV : m_cnt[i] + 1)
                                                 : (m_cnt[i] == 0 ? 0 : m_cnt[i] - 1);
            m_left--;
            if (m_left == 0) begin
               m_win = 0; m_busy = 0; m_done = 1;
               for (int i = 0; i < NC; i++) m_state[i] = m_cnt[i] >= MIDV;
            end
         end
      end
   end
   always @(negedge clk) begin
      if (m_live) begin
         logic [31:0] exp_bins;
         for (int i = 0; i < NC; i++) exp_bins[i*W +: W] = W'(m_cnt[i]);
         check("model_bin_count", bus.bin_count_out, exp_bins);
         check("model_state_out", 32'(bus.state_out), 32'(m_state));
         check("model_done_out", 32'(bus.done_out), 32'(m_done));
         check("model_busy_out", 32'(bus.busy_out), 32'(m_busy));
      end
   end
   task automatic cyc(input bit r, input bit st, input logic [7:0] wl, input bit v, input logic [3:0] cc);
      rst = r;
      bus.start_count = st;
      bus.window_len = wl;
      bus.valid_in = v;
      bus.count_condition = cc;
      @(posedge clk);
      @(negedge clk);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end
   initial begin
      logic [3:0] gap_seq;
      gap_seq = 4'b0101;
      rst = 1'b1;
      bus.start_count = 1'b0;
      bus.window_len = '0;
      bus.valid_in = 1'b0;
      bus.count_condition = '0;
      repeat (3) cyc(1, 0, 0, 0, 4'h0);
      check("rst_bins", bus.bin_count_out, 32'h0);
      check("rst_state", 32'(bus.state_out), 32'h0);
      check("rst_done", 32'(bus.done_out), 32'h0);
      check("rst_busy", 32'(bus.busy_out), 32'h0);
      repeat (3) cyc(0, 0, 0, 1, 4'hF);
      check("idle_valid_bins", bus.bin_count_out, 32'h0);
      cyc(0, 1, 5, 0, 4'h0);
      check("basic_busy", 32'(bus.busy_out), 32'h1);
      repeat (5) cyc(0, 0, 0, 1, 4'b0101);
      check("basic_done", 32'(bus.done_out), 32'h1);
      check("basic_state", 32'(bus.state_out), 32'h5);
      check("basic_bins", bus.bin_count_out, {8'd123, 8'd133, 8'd123, 8'd133});
      cyc(0, 0, 0, 0, 4'h0);
      check("basic_done_drop", 32'(bus.done_out), 32'h0);
      check("basic_busy_low", 32'(bus.busy_out), 32'h0);
      cyc(0, 1, 4, 0, 4'h0);
      for (int k = 0; k < 4; k++) begin
         cyc(0, 0, 0, 1, {3'b000, gap_seq[k]});
         if (k == 3) begin
            check("gap_done", 32'(bus.done_out), 32'h1);
            check("gap_ch0", 32'(bus.bin_count_out[7:0]), 32'd128);
            check("gap_state", 32'(bus.state_out), 32'h1);
         end else check("gap_no_early_done", 32'(bus.done_out), 32'h0);
         cyc(0, 0, 0, 0, 4'hF);
      end
      cyc(0, 1, 200, 0, 4'h0);
      repeat (200) cyc(0, 0, 0, 1, 4'hF);
      check("sat_up_bins", bus.bin_count_out, 32'hFFFF_FFFF);
      check("sat_up_state", 32'(bus.state_out), 32'hF);
      cyc(0, 1, 200, 0, 4'h0);
      repeat (200) cyc(0, 0, 0, 1, 4'h0);
      check("sat_dn_bins", bus.bin_count_out, 32'h0);
      check("sat_dn_state", 32'(bus.state_out), 32'h0);
      check("sat_dn_done", 32'(bus.done_out), 32'h1);
      cyc(0, 1, 10, 0, 4'h0);
      repeat (3) cyc(0, 0, 0, 1, 4'hF);
      check("restart_pre", bus.bin_count_out, {4{8'd131}});
      cyc(0, 1, 2, 1, 4'hF);
      check("restart_reload", bus.bin_count_out, {4{8'd128}});
      check("restart_no_done", 32'(bus.done_out), 32'h0);
      check("restart_busy", 32'(bus.busy_out), 32'h1);
      repeat (2) cyc(0, 0, 0, 1, 4'hF);
      check("restart_done", 32'(bus.done_out), 32'h1);
      check("restart_bins", bus.bin_count_out, {4{8'd130}});
      cyc(0, 0, 0, 0, 4'h0);
      cyc(0, 1, 0, 0, 4'h0);
      check("zero_done", 32'(bus.done_out), 32'h1);
      check("zero_state", 32'(bus.state_out), 32'hF);
      check("zero_bins", bus.bin_count_out, {4{8'd128}});
      cyc(0, 1, 3, 0, 4'h0);
      check("b2b_busy", 32'(bus.busy_out), 32'h1);
      check("b2b_done", 32'(bus.done_out), 32'h0);
      cyc(0, 0, 0, 1, 4'hF);
      check("b2b_count", bus.bin_count_out, {4{8'd129}});
      cyc(1, 0, 0, 1, 4'hF);
      check("midrst_bins", bus.bin_count_out, 32'h0);
      check("midrst_busy", 32'(bus.busy_out), 32'h0);
      check("midrst_done", 32'(bus.done_out), 32'h0);
      check("midrst_state", 32'(bus.state_out), 32'h0);
      repeat (3) cyc(0, 0, 0, 1, 4'hF);
      check("post_rst_idle_done", 32'(bus.done_out), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
